packetizer_2_sub: RTL and testbench

Transmit-side translator. It accepts a data word with a destination and VC over a valid/ready handshake, and formats it as a two-flit NoC packet: a head flit carrying control, VC, destination and upper data bits, and a tail flit carrying control, VC and the remaining data bits. Output is registered through a two-entry skid buffer, so the block sustains one packet per cycle and ready is timing-isolated. The packet bit layout matches exactly what depacketizer_2_sub strips on the receive end.

---
 rtl/packetizer_2_sub.sv | 135 +++++++++++++
 tb/tb_packetizer_2_sub.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packetizer_2_sub.sv
// packetizer_2_sub: formats a data word with its destination and VC into a
// two-flit NoC packet (head + tail) and presents it through a two-entry
// output skid buffer.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. Once a source raises valid it holds valid
// and its payload steady until that transfer. ready may move freely and is
// never derived combinationally from valid on the same side.
//
// Packet layout, MSB first:
//   head flit: {valid=1, head=1, tail=0, vc, dest, full_data[upper HEAD_DATA_W]}
//   tail flit: {valid=1, head=0, tail=1, vc, full_data[lower TAIL_DATA_W]}
// full_data is the user data MSB-aligned in WIDTH_DATA_IDL bits, zero-padded.
// This layout matches what the receive-side depacketizer strips.
module packetizer_2_sub #(
    parameter int WIDTH_PKT        = 36,
    parameter int WIDTH_DATA       = 12,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int ADDRESS_WIDTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH_DATA-1:0]       data_in,
    input  logic [ADDRESS_WIDTH-1:0]    dest_in,
    input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    output logic [WIDTH_PKT-1:0]        data_out,
    output logic                        valid_out,
    input  logic                        ready_in
);

    // Derived geometry; these follow from the packet format and are not
    // meant to be overridden.
    localparam int WIDTH_FLIT     = WIDTH_PKT / 2;
    localparam int WIDTH_DATA_IDL = WIDTH_PKT - 6 - 2 * VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
    localparam int HEAD_DATA_W    = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
    localparam int TAIL_DATA_W    = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH;
    localparam int PAD_W          = WIDTH_DATA_IDL - WIDTH_DATA;

    // Flit control codes: {valid, head, tail}
    localparam logic [2:0] CTRL_HEAD = 3'b110;
    localparam logic [2:0] CTRL_TAIL = 3'b101;

    // Buffer occupancy: EMPTY (nothing held), ONE (main only),
    // FULL (main and skid). Kept as a named signal so checkers can bind to it.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                    state_q;
    logic [WIDTH_PKT-1:0]      main_pkt;
    logic [WIDTH_PKT-1:0]      skid_pkt;

    logic [WIDTH_DATA_IDL-1:0] full_data;
    logic [WIDTH_FLIT-1:0]     head_flit;
    logic [WIDTH_FLIT-1:0]     tail_flit;
    logic [WIDTH_PKT-1:0]      fmt_pkt;
    logic                      accept;
    logic                      send;

    // Data is MSB-aligned; a shift (rather than a replication) also covers
    // the case where the data exactly fills the idle field and PAD_W is 0.
    assign full_data = WIDTH_DATA_IDL'(data_in) << PAD_W;

    // Purely combinational formatting of the incoming word
    assign head_flit = {CTRL_HEAD, vc_in, dest_in,
                        full_data[WIDTH_DATA_IDL-1 -: HEAD_DATA_W]};
    assign tail_flit = {CTRL_TAIL, vc_in, full_data[TAIL_DATA_W-1:0]};
    assign fmt_pkt   = {head_flit, tail_flit};

    assign accept = valid_in & ready_out;
    assign send   = valid_out & ready_in;

    // Only a held packet is shown; otherwise the bus is forced to zero so the
    // flit valid bits read as a clean 0.
    assign data_out = valid_out ? main_pkt : '0;

    // Occupancy FSM with registered valid_out/ready_out and packet storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            main_pkt  <= '0;
            skid_pkt  <= '0;
            valid_out <= 1'b0;
            ready_out <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_pkt  <= fmt_pkt;
                        state_q   <= ST_ONE;
                        valid_out <= 1'b1;
                        ready_out <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && send) begin
                        // Replace the departing packet on the same edge: no bubble
                        main_pkt <= fmt_pkt;
                    end else if (accept) begin
                        // Downstream stalled: park the new packet in skid and
                        // close the input for the next cycle
                        skid_pkt  <= fmt_pkt;
                        state_q   <= ST_FULL;
                        ready_out <= 1'b0;
                    end else if (send) begin
                        main_pkt  <= '0;
                        state_q   <= ST_EMPTY;
                        valid_out <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // ready_out is low here, so nothing can be accepted
                    if (send) begin
                        main_pkt  <= skid_pkt;
                        skid_pkt  <= '0;
                        state_q   <= ST_ONE;
                        ready_out <= 1'b1;
                    end
                end
                default: begin
                    main_pkt  <= '0;
                    skid_pkt  <= '0;
                    state_q   <= ST_EMPTY;
                    valid_out <= 1'b0;
                    ready_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packetizer_2_sub.sv
// Testbench for packetizer_2_sub: directed scenarios plus a long random
// valid/ready run. Expected packets come from a field-level model of the
// packet format; a monitor pops and compares them as the DUT sends.
module tb_packetizer_2_sub;

    localparam int WP = 36;
    localparam int WD = 12;
    localparam int WV = 1;
    localparam int WA = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic [WD-1:0] data_in;
    logic [WA-1:0] dest_in;
    logic [WV-1:0] vc_in;
    logic          valid_in;
    logic          ready_out;
    logic [WP-1:0] data_out;
    logic          valid_out;
    logic          ready_in;

    always #5 clk = ~clk;

    packetizer_2_sub #(
        .WIDTH_PKT(WP), .WIDTH_DATA(WD), .VC_ADDRESS_WIDTH(WV), .ADDRESS_WIDTH(WA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
        .vc_in(vc_in), .valid_in(valid_in), .ready_out(ready_out),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in)
    );

    // ---------------- scoreboard state ----------------
    // Each entry: {expected packet, original data word}
    logic [WP+WD-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // pending source word (held until accepted)
    bit            pend = 0;
    logic [WD-1:0] p_d   = '0;
    logic [WA-1:0] p_dst = '0;
    logic [WV-1:0] p_vc  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: build the packet from its fields with plain arithmetic
    function automatic logic [WP-1:0] model_pkt(input logic [WD-1:0] d,
                                                input logic [WA-1:0] dst,
                                                input logic [WV-1:0] vc);
        longint unsigned full, head, tail;
        full = longint'(d) * (64'd1 << 12);                // MSB-align 12 bits into 24
        head = 64'd6 * (64'd1 << 15) + longint'(vc) * (64'd1 << 14)
             + longint'(dst) * (64'd1 << 10) + full / (64'd1 << 14);
        tail = 64'd5 * (64'd1 << 15) + longint'(vc) * (64'd1 << 14)
             + full % (64'd1 << 14);
        return WP'(head * (64'd1 << 18) + tail);
    endfunction

    // Receive-side view: recover the user data word from a packet
    function automatic logic [WD-1:0] depacketize(input logic [WP-1:0] p);
        longint unsigned pv, full;
        pv   = longint'(p);
        full = ((pv >> 18) % (64'd1 << 10)) * (64'd1 << 14) + pv % (64'd1 << 14);
        return WD'(full >> 12);
    endfunction

    // ---------------- driver ----------------
    // One cycle: drive at negedge, decide acceptance just before the next edge.
    task automatic step(input bit new_ok, input logic rdy, output bit acc);
        @(negedge clk);
        if (!pend && new_ok) begin
            pend  = 1;
            p_d   = WD'($urandom_range(0, 4095));
            p_dst = WA'($urandom_range(0, 15));
            p_vc  = WV'($urandom_range(0, 1));
        end
        valid_in = pend;
        data_in  = p_d;
        dest_in  = p_dst;
        vc_in    = p_vc;
        ready_in = rdy;
        #1;
        acc = pend && (ready_out === 1'b1);
        if (acc) begin
            exp_q.push_back({model_pkt(p_d, p_dst, p_vc), p_d});
            pend = 0;
        end
    endtask

    task automatic load(input logic [WD-1:0] d, input logic [WA-1:0] dst, input logic [WV-1:0] vc);
        pend  = 1;
        p_d   = d;
        p_dst = dst;
        p_vc  = vc;
    endtask

    // ---------------- monitor ----------------
    bit            prev_stall = 0;
    logic [WP-1:0] prev_data  = '0;

    initial begin
        logic [WP+WD-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n !== 1'b1) begin
                prev_stall = 0;
            end else begin
                if (valid_out === 1'b0)
                    check("idle_data_zero", 64'(data_out), 64'd0);
                if (prev_stall) begin
                    check("stall_valid_hold", 64'(valid_out), 64'd1);
                    check("stall_data_hold", 64'(data_out), 64'(prev_data));
                end
                if (valid_out === 1'b1 && ready_in === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_packet: got %0h expected none at %0t", data_out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("packet", 64'(data_out), 64'(e[WP+WD-1:WD]));
                        check("recovered_data", 64'(depacketize(data_out)), 64'(e[WD-1:0]));
                    end
                end
                prev_stall = (valid_out === 1'b1) && (ready_in === 1'b0);
                prev_data  = data_out;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit acc;
        int n_acc;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        dest_in  = '0;
        vc_in    = '0;
        ready_in = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid_out", 64'(valid_out), 64'd0);
        check("reset_data_out", 64'(data_out), 64'd0);
        check("reset_ready_out", 64'(ready_out), 64'd1);
        rst_n = 1'b1;

        // Single transfer
        load(12'hABC, 4'h5, 1'b1);
        step(0, 1'b1, acc);
        check("single_accept", 64'(acc), 64'd1);
        step(0, 1'b1, acc);
        check("single_valid", 64'(valid_out), 64'd1);
        check("single_ready", 64'(ready_out), 64'd1);
        check("single_pkt", 64'(data_out), 64'(model_pkt(12'hABC, 4'h5, 1'b1)));
        step(0, 1'b1, acc);
        check("single_one_cycle", 64'(valid_out), 64'd0);
        check("single_ready_after", 64'(ready_out), 64'd1);

        // Back-to-back: data 0..7, no gaps
        for (int i = 0; i < 8; i++) begin
            load(WD'(i), WA'(i), WV'(i % 2));
            step(0, 1'b1, acc);
            check("b2b_accept", 64'(acc), 64'd1);
            if (i > 0) check("b2b_valid", 64'(valid_out), 64'd1);
        end
        step(0, 1'b1, acc);
        check("b2b_last_valid", 64'(valid_out), 64'd1);
        repeat (2) step(0, 1'b1, acc);

        // Backpressure: stream while stalled
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 1'b0, acc);
            if (acc) n_acc++;
            if (i >= 2) check("bp_ready_low", 64'(ready_out), 64'd0);
        end
        check("bp_buffered", 64'(n_acc), 64'd2);
        step(0, 1'b1, acc);
        check("bp_ready_still_low", 64'(ready_out), 64'd0);
        step(0, 1'b1, acc);
        check("bp_ready_back", 64'(ready_out), 64'd1);
        check("bp_held_accept", 64'(acc), 64'd1);
        repeat (4) step(0, 1'b1, acc);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Random valid/ready
        for (int i = 0; i < 10000; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, acc);
        for (int i = 0; i < 50 && (exp_q.size() != 0 || pend); i++)
            step(0, 1'b1, acc);
        check("random_drained", 64'(exp_q.size()), 64'd0);
        check("random_no_pending", 64'(pend), 64'd0);

        // Async reset while FULL
        step(1, 1'b0, acc);
        step(1, 1'b0, acc);
        step(1, 1'b0, acc);
        check("full_before_reset", 64'(ready_out), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid_out", 64'(valid_out), 64'd0);
        check("arst_data_out", 64'(data_out), 64'd0);
        check("arst_ready_out", 64'(ready_out), 64'd1);
        exp_q.delete();
        pend     = 0;
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;

        // Idle: bus must read as clean zeros
        for (int i = 0; i < 20; i++) begin
            step(0, 1'($urandom_range(0, 1)), acc);
            check("idle_valid", 64'(valid_out), 64'd0);
            check("idle_bit35", 64'(data_out[35]), 64'd0);
            check("idle_bit17", 64'(data_out[17]), 64'd0);
        end

        // Post-idle transfer still works after the reset
        load(12'h5A3, 4'hC, 1'b0);
        step(0, 1'b1, acc);
        repeat (3) step(0, 1'b1, acc);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
